// File: rtl/arb_pkg.sv
// arb_pkg: definitions private to the RAM arbiter.
//   arb_state_t         - arbiter FSM states (IDLE/DGNT/IGNT/RESP)
//   TIMEOUT_CYC_DEFAULT - default number of grant cycles allowed without
//                         ACCESS before the grant is aborted
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DGNT = 2'd1,
      IGNT = 2'd2,
      RESP = 2'd3
   } arb_state_t;

   localparam int TIMEOUT_CYC_DEFAULT = 255;

endpackage

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: types shared between the datapath and the memory subsystem.
//   word_t     - 32-bit machine word
//   ramstate_t - state reported by the unified RAM model
//                (FREE=0, BUSY=1, ACCESS=2, ERROR=3)
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/arb_timer.sv
// arb_timer: 8-bit saturating event counter with synchronous clear.
// Used by the arbiter as the grant wait counter and, when fairness is
// enabled, as the data-starvation counter.
//
// Ports:
//   CLK      in   clock
//   nRST     in   asynchronous active-low reset (count -> 0)
//   clr      in   synchronous clear (has priority over en)
//   en       in   count one event
//   at_limit out  count has reached LIMIT (count stops there)
//
// Parameter LIMIT must be in 0..255.
module arb_timer #(
   parameter int LIMIT = 255
) (
   input  logic CLK,
   input  logic nRST,
   input  logic clr,
   input  logic en,
   output logic at_limit
);

   logic [7:0] count;

   assign at_limit = (count >= 8'(LIMIT));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !at_limit) begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between instruction fetch and data
// memory. Data requests have priority; each transaction runs
// IDLE -> grant (DGNT/IGNT) -> RESP -> IDLE, and the response data plus a
// one-cycle hit pulse are registered.
//
// Ports:
//   CLK, nRST               clock, asynchronous active-low reset
//   iREN, iaddr             instruction read request / word address
//   iload, ihit             registered instruction data / response pulse
//   dREN, dWEN, daddr       data read / write request (dWEN wins), address
//   dstore                  data write value
//   dload, dhit             registered data read result / response pulse
//   ramREN, ramWEN          RAM read / write enable
//   ramaddr, ramstore       RAM address / write data
//   ramload, ramstate       RAM read data / RAM state (FREE/BUSY/ACCESS/ERROR)
//   arb_err                 pulse: RAM ERROR or timeout on the current grant
//
// Parameters:
//   TIMEOUT_CYC  grant cycles without ACCESS before abort (1..255)
//   STARVE_MAX   consecutive data grants taken with iREN pending before an
//                instruction grant is forced (fairness build only, 1..255)
//
// Build option: define MEM_ARBITER_FAIR_EN to enable the starvation counter.
// Without it the arbiter gives data strict priority.
module mem_arbiter
   import cpu_types_pkg::*;
   import arb_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
   parameter int STARVE_MAX  = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        ihit,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dhit,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        arb_err
);

   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255 || STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_param
      $error("mem_arbiter: TIMEOUT_CYC and STARVE_MAX must be in 1..255");
   end

   arb_state_t state;
   ramstate_t  rs;
   logic       d_req;
   logic       in_grant;
   logic       go_dgnt;
   logic       go_ignt;
   logic       fair_force;
   logic       wait_at_limit;
   logic       timed_out;

   assign rs       = ramstate_t'(ramstate);
   assign d_req    = dREN | dWEN;
   assign in_grant = (state == DGNT) || (state == IGNT);

   // Grant decision, evaluated only in IDLE. fair_force overrides data
   // priority once fetch has been passed over STARVE_MAX times.
   assign go_ignt = (state == IDLE) && (fair_force || (iREN && !d_req));
   assign go_dgnt = (state == IDLE) && d_req && !fair_force;

   // The counter holds the number of non-ACCESS grant cycles already spent,
   // so the TIMEOUT_CYC-th such cycle sees count == TIMEOUT_CYC-1 and aborts
   // at its closing edge.
   arb_timer #(
      .LIMIT (TIMEOUT_CYC - 1)
   ) u_wait_timer (
      .CLK      (CLK),
      .nRST     (nRST),
      .clr      (!in_grant),
      .en       (in_grant && (rs != ACCESS)),
      .at_limit (wait_at_limit)
   );

   assign timed_out = wait_at_limit && (rs != ACCESS);

`ifdef MEM_ARBITER_FAIR_EN
   logic starve_at_limit;

   // Counts data grants taken while fetch was waiting; any instruction
   // grant resets it.
   arb_timer #(
      .LIMIT (STARVE_MAX)
   ) u_starve_timer (
      .CLK      (CLK),
      .nRST     (nRST),
      .clr      (go_ignt),
      .en       (go_dgnt && iREN),
      .at_limit (starve_at_limit)
   );

   assign fair_force = starve_at_limit && iREN;
`else
   assign fair_force = 1'b0;
`endif

   // FSM with registered response data, hit pulses and error pulse.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= IDLE;
         iload   <= '0;
         dload   <= '0;
         ihit    <= 1'b0;
         dhit    <= 1'b0;
         arb_err <= 1'b0;
      end else begin
         ihit    <= 1'b0;
         dhit    <= 1'b0;
         arb_err <= 1'b0;
         case (state)
            IDLE: begin
               if (go_ignt) begin
                  state <= IGNT;
               end else if (go_dgnt) begin
                  state <= DGNT;
               end
            end
            DGNT: begin
               // A withdrawn request ends the grant silently; otherwise
               // ACCESS completes it, ERROR or timeout aborts it.
               if (!d_req) begin
                  state <= IDLE;
               end else if (rs == ACCESS) begin
                  if (!dWEN) begin
                     dload <= ramload;
                  end
                  dhit  <= 1'b1;
                  state <= RESP;
               end else if (rs == ERROR || timed_out) begin
                  arb_err <= 1'b1;
                  state   <= IDLE;
               end
            end
            IGNT: begin
               if (!iREN) begin
                  state <= IDLE;
               end else if (rs == ACCESS) begin
                  iload <= ramload;
                  ihit  <= 1'b1;
                  state <= RESP;
               end else if (rs == ERROR || timed_out) begin
                  arb_err <= 1'b1;
                  state   <= IDLE;
               end
            end
            RESP: begin
               // The requester still holds its request this cycle; taking
               // no grant here keeps it from being served twice.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // RAM side follows the live request inputs while granted.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      case (state)
         DGNT: begin
            ramaddr  = daddr;
            ramWEN   = dWEN;
            ramREN   = dREN && !dWEN;
            ramstore = dstore;
         end
         IGNT: begin
            ramaddr = iaddr;
            ramREN  = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
